vga_capture_ctrl: RTL and testbench

VGA_CAPTURE_CTRL -- requirements
Module: vga_capture_ctrl

---
 rtl/vga_capture_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_vga_capture_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture_ctrl.sv
// vga_capture_ctrl: arms on a start request, then captures whole VGA frames
// between falling edges of vs and hands each pixel to a capture sink.
// Latency: a vs falling edge seen in ARM puts pixel (0,0) on x/y one cycle later.
//   frame_done pulses in the cycle after the last pixel, and seq_done one cycle after that.
// Backpressure: none. The sink must accept one pixel per cycle while cap_pix_en is high.
// Optional feature: define CAPTURE_CRC_EN to add a per-frame CRC-16-CCITT output.
//
// Ports:
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   vs, rgb                 vertical sync (falling edge = frame boundary), pixel colour {r,g,b}
//   start, num_frames       capture request pulse and frame count (0 is treated as 1)
//   abort                   cancel the sequence and return to IDLE
//   busy                    state is not IDLE
//   cap_go, cap_pix_en      sink go and sink write strobe, both high during CAPTURE
//   x, y                    coordinates of the current captured pixel
//   frame_done, seq_done    single-cycle completion pulses
//   frames_left             frames still to be captured
//   err_short               sticky flag: a frame was truncated by an early vs edge
//   crc (CAPTURE_CRC_EN)    CRC of the current or most recent frame
module vga_capture_ctrl #(
  parameter int XDIM     = 1056,
  parameter int YDIM     = 628,
  parameter int FRAMES_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vs,
  input  logic [11:0]         rgb,
  input  logic                start,
  input  logic [FRAMES_W-1:0] num_frames,
  input  logic                abort,
  output logic                busy,
  output logic                cap_go,
  output logic                cap_pix_en,
  output logic [10:0]         x,
  output logic [9:0]          y,
  output logic                frame_done,
  output logic                seq_done,
  output logic [FRAMES_W-1:0] frames_left,
  output logic                err_short
`ifdef CAPTURE_CRC_EN
  ,
  output logic [15:0]         crc
`endif
);

  localparam logic [10:0] X_LAST = 11'(XDIM - 1);
  localparam logic [9:0]  Y_LAST = 10'(YDIM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_d;
  logic [10:0]         x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic [FRAMES_W-1:0] frames_left_q, frames_left_d;
  logic                err_short_q, err_short_d;
  logic                frame_done_q, frame_done_d;
  logic                seq_done_q, seq_done_d;

  logic vs_fall;
  logic last_px;

  assign vs_fall = vs_q & ~vs;
  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d       = state_q;
    vs_d          = vs;
    x_d           = x_q;
    y_d           = y_q;
    frames_left_d = frames_left_q;
    err_short_d   = err_short_q;
    frame_done_d  = 1'b0;
    seq_done_d    = 1'b0;

    if (abort) begin
      // Abort overrides start and vs edges. err_short is kept for post-mortem.
      state_d       = IDLE;
      x_d           = '0;
      y_d           = '0;
      frames_left_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            frames_left_d = (num_frames == '0) ? FRAMES_W'(1) : num_frames;
            err_short_d   = 1'b0;
            state_d       = ARM;
          end
        end
        ARM: begin
          if (vs_fall) begin
            state_d = CAPTURE;
            x_d     = '0;
            y_d     = '0;
          end
        end
        CAPTURE: begin
          if (last_px) begin
            frame_done_d  = 1'b1;
            frames_left_d = frames_left_q - FRAMES_W'(1);
            x_d           = '0;
            y_d           = '0;
            if (frames_left_q <= FRAMES_W'(1)) begin
              state_d = DONE;
            end else if (vs_fall) begin
              // A boundary that coincides with the last pixel starts the next
              // frame immediately, so back-to-back frames are not dropped.
              state_d = CAPTURE;
            end else begin
              state_d = ARM;
            end
          end else if (vs_fall) begin
            // The frame was cut short. Restart at the origin and keep the frame count.
            err_short_d = 1'b1;
            x_d         = '0;
            y_d         = '0;
          end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 10'd1;
          end else begin
            x_d = x_q + 11'd1;
          end
        end
        DONE: begin
          // seq_done is registered, so it appears in the first IDLE cycle.
          seq_done_d = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vs_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frames_left_q <= '0;
      err_short_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      seq_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frames_left_q <= frames_left_d;
      err_short_q   <= err_short_d;
      frame_done_q  <= frame_done_d;
      seq_done_q    <= seq_done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign cap_go      = (state_q == CAPTURE);
  assign cap_pix_en  = (state_q == CAPTURE);
  assign x           = x_q;
  assign y           = y_q;
  assign frames_left = frames_left_q;
  assign err_short   = err_short_q;
  assign frame_done  = frame_done_q;
  assign seq_done    = seq_done_q;

`ifdef CAPTURE_CRC_EN
  logic [15:0] crc_q, crc_d;

  // CRC-16-CCITT, polynomial 0x1021, MSB first, over one 16-bit word.
  function automatic logic [15:0] crc16_word(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    c = c_in;
    for (int b = 15; b >= 0; b--) begin
      if (c[15] ^ d[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Pixel (0,0) seeds the CRC from 0xFFFF. This covers ARM entry, back-to-back
  // entry and a short-frame restart. Outside CAPTURE the last value is held.
  always_comb begin
    crc_d = crc_q;
    if (state_q == CAPTURE) begin
      crc_d = crc16_word(((x_q == '0) && (y_q == '0)) ? 16'hFFFF : crc_q, {4'h0, rgb});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 16'hFFFF;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb;
`endif

endmodule

// File: tb/tb_vga_capture_ctrl.sv
// tb_vga_capture_ctrl: directed scenarios against vga_capture_ctrl with XDIM=8 and YDIM=4.
// Stimulus pushes the expected pixels, frame_done counts and seq_done events into queues.
// A negedge monitor pops and compares them whenever the DUT presents them.
module tb_vga_capture_ctrl;
  localparam int XD = 8;
  localparam int YD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs;
  logic [11:0] rgb;
  logic        start;
  logic [3:0]  num_frames;
  logic        abort;
  logic        busy, cap_go, cap_pix_en, frame_done, seq_done, err_short;
  logic [10:0] x;
  logic [9:0]  y;
  logic [3:0]  frames_left;
`ifdef CAPTURE_CRC_EN
  logic [15:0] crc;
`endif

  always #5 clk = ~clk;

  vga_capture_ctrl #(.XDIM(XD), .YDIM(YD), .FRAMES_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .rgb(rgb), .start(start),
    .num_frames(num_frames), .abort(abort), .busy(busy), .cap_go(cap_go),
    .cap_pix_en(cap_pix_en), .x(x), .y(y), .frame_done(frame_done),
    .seq_done(seq_done), .frames_left(frames_left), .err_short(err_short)
`ifdef CAPTURE_CRC_EN
    , .crc(crc)
`endif
  );

  typedef struct packed {
    logic [10:0] px;
    logic [9:0]  py;
  } px_t;

  px_t        pix_q[$];
  logic [3:0] fd_q[$];
  int         sd_pend = 0;
  int         n_pass  = 0;
  int         n_total = 0;
  px_t        mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      pix_q.push_back('{px: 11'(k % XD), py: 10'(k / XD)});
    end
  endtask

  // Drive one vs falling edge. Return in the cycle after the edge is seen.
  task automatic vs_edge();
    vs = 1'b0;
    step();
    vs = 1'b1;
  endtask

  task automatic issue_start(input logic [3:0] n);
    num_frames = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk(nm, busy, 0);
  endtask

  function automatic logic [15:0] crc_ref(input int npix, input logic [15:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int p = 0; p < npix; p++) begin
      for (int b = 15; b >= 0; b--) begin
        if (c[15] ^ d[b]) c = (c << 1) ^ 16'h1021;
        else              c = c << 1;
      end
    end
    return c;
  endfunction

  // Monitor: compares each DUT output event with the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cap_pix_en) begin
        chk("pix_pending", 32'(pix_q.size() > 0), 1);
        if (pix_q.size() > 0) begin
          mon_e = pix_q.pop_front();
          chk("pix_xy", {x, y}, {mon_e.px, mon_e.py});
        end
      end
      if (frame_done) begin
        chk("frame_done_pending", 32'(fd_q.size() > 0), 1);
        if (fd_q.size() > 0) chk("frame_done_left", frames_left, fd_q.pop_front());
      end
      if (seq_done) begin
        chk("seq_done_pending", 32'(sd_pend > 0), 1);
        if (sd_pend > 0) sd_pend--;
        chk("seq_done_busy", busy, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vs = 1'b1; rgb = 12'h000; start = 1'b0; num_frames = 4'd0; abort = 1'b0;
    #2;
    chk("reset_outs", {busy, cap_go, cap_pix_en, frame_done, seq_done, err_short, x, y, frames_left}, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // S1: a single frame of 32 pixels with constant rgb=0.
    issue_start(4'd1);
    chk("s1_busy", busy, 1);
    chk("s1_left", frames_left, 1);
    push_pix(0, 31); fd_q.push_back(4'd0); sd_pend++;
    vs_edge();
    chk("s1_capgo", cap_go, 1);
    wait_idle("s1_idle");
    step();
`ifdef CAPTURE_CRC_EN
    chk("s1_crc", crc, crc_ref(32, 16'h0000));
`endif

    // S2: three frames with vs edges exactly 32 cycles apart.
    rgb = 12'h5A3;
    issue_start(4'd3);
    push_pix(0, 31); push_pix(0, 31); push_pix(0, 31);
    fd_q.push_back(4'd2); fd_q.push_back(4'd1); fd_q.push_back(4'd0); sd_pend++;
    vs_edge();
    repeat (31) step();
    vs_edge();
    repeat (31) step();
    vs_edge();
    wait_idle("s2_idle");
    chk("s2_err_short", err_short, 0);
    step();

    // S3: a vs edge at pixel 20 truncates the frame.
    issue_start(4'd2);
    push_pix(0, 20);
    vs_edge();
    repeat (20) step();
    vs_edge();
    chk("s3_err_short", err_short, 1);
    chk("s3_xy", {x, y}, 0);
    chk("s3_left", frames_left, 2);
    chk("s3_capture", cap_pix_en, 1);
    push_pix(0, 31); fd_q.push_back(4'd1);
    repeat (32) step();
    chk("s3_arm_capgo", cap_go, 0);
    chk("s3_arm_left", frames_left, 1);

    // S4: abort at pixel 10.
    push_pix(0, 10);
    vs_edge();
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s4_abort_state", {busy, cap_go, cap_pix_en}, 0);
    chk("s4_abort_left", frames_left, 0);
    chk("s4_abort_xy", {x, y}, 0);
    chk("s4_err_kept", err_short, 1);
    step();

    // S5: num_frames=0 captures one frame. Starts while busy are ignored.
    issue_start(4'd0);
    chk("s5_left", frames_left, 1);
    chk("s5_err_clr", err_short, 0);
    issue_start(4'd5);
    chk("s5_ign_arm", frames_left, 1);
    push_pix(0, 31); fd_q.push_back(4'd0); sd_pend++;
    vs_edge();
    repeat (5) step();
    issue_start(4'd7);
    chk("s5_ign_cap", frames_left, 1);
    wait_idle("s5_idle");
    step();

    // S6: reset in the middle of a frame.
    issue_start(4'd2);
    push_pix(0, 4);
    vs_edge();
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("s6_reset_outs", {busy, cap_go, cap_pix_en, frame_done, seq_done, err_short, x, y, frames_left}, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("s6_after_busy", busy, 0);

    chk("pix_q_empty", pix_q.size(), 0);
    chk("fd_q_empty", fd_q.size(), 0);
    chk("sd_empty", sd_pend, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
